// File: rtl/mem_cache.sv
// Direct-mapped, write-through read cache between the MEM stage and SRAM.
// 64-bit lines, zero-latency read hits, no write-allocate.
module mem_cache #(
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Mem_R_EN,
  input  logic             Mem_W_EN,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             Ready,
  output logic             sram_R_EN,
  output logic             sram_W_EN,
  output logic [31:0]      sram_addr,
  output logic [31:0]      sram_wdata,
  input  logic [63:0]      sram_rdata,
  input  logic             sram_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 32 - INDEX_W - 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nx;

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [63:0]        data_mem [LINES];

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic               ws;
  logic [63:0]        line;
  logic               hit;
  logic [31:0]        hit_word;
  logic [31:0]        fill_word;

  logic               w_req;
  logic               rd_hit;
  logic               rd_miss;

  logic               hit_ev;
  logic               miss_ev;
  logic               fill_we;
  logic               word_we;

  assign tag       = addr[31:INDEX_W+3];
  assign idx       = addr[INDEX_W+2:3];
  assign ws        = addr[2];
  assign line      = data_mem[idx];
  assign hit       = valid[idx] && (tag_mem[idx] == tag);
  assign hit_word  = ws ? line[63:32] : line[31:0];
  assign fill_word = ws ? sram_rdata[63:32]
                        : sram_rdata[31:0];

  // Write wins over a simultaneous read.
  assign w_req   = Mem_W_EN;
  assign rd_hit  = Mem_R_EN && !Mem_W_EN && hit;
  assign rd_miss = Mem_R_EN && !Mem_W_EN && !hit;

  always_comb begin
    state_nx   = state;
    Ready      = 1'b0;
    rdata      = 32'h0;
    sram_R_EN  = 1'b0;
    sram_W_EN  = 1'b0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    hit_ev     = 1'b0;
    miss_ev    = 1'b0;
    fill_we    = 1'b0;
    word_we    = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          w_req: begin
            state_nx = WRITE;
          end
          rd_hit: begin
            Ready  = 1'b1;
            rdata  = hit_word;
            hit_ev = 1'b1;
          end
          rd_miss: begin
            miss_ev  = 1'b1;
            state_nx = FILL;
          end
          default: begin
            Ready = 1'b1;
          end
        endcase
      end
      FILL: begin
        sram_R_EN = 1'b1;
        sram_addr = {addr[31:3], 3'b000};
        if (sram_ready) begin
          Ready    = 1'b1;
          rdata    = fill_word;
          fill_we  = 1'b1;
          state_nx = IDLE;
        end
      end
      WRITE: begin
        sram_W_EN  = 1'b1;
        sram_addr  = addr;
        sram_wdata = wdata;
        if (sram_ready) begin
          Ready    = 1'b1;
          word_we  = hit;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      valid    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nx;
      if (fill_we) begin
        valid[idx] <= 1'b1;
      end
      if (hit_ev && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
      if (miss_ev && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

  // Tag/data contents need no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= sram_rdata;
    end else if (word_we) begin
      if (ws) begin
        data_mem[idx][63:32] <= wdata;
      end else begin
        data_mem[idx][31:0] <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_cache.sv
// Bench for mem_cache: cache/SRAM reference model plus a
// per-cycle compare process and hand-computed literal pins.
module tb_mem_cache;

  localparam int CW = 4;
  localparam int IW = 6;
  localparam int NL = 1 << IW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Mem_R_EN = 1'b0;
  logic          Mem_W_EN = 1'b0;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic [31:0]   rdata;
  logic          Ready;
  logic          sram_R_EN;
  logic          sram_W_EN;
  logic [31:0]   sram_addr;
  logic [31:0]   sram_wdata;
  logic [63:0]   sram_rdata = 64'h0;
  logic          sram_ready = 1'b0;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  mem_cache #(.INDEX_W(IW), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .Mem_R_EN(Mem_R_EN),
    .Mem_W_EN(Mem_W_EN),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .Ready(Ready),
    .sram_R_EN(sram_R_EN),
    .sram_W_EN(sram_W_EN),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_ready(sram_ready),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: cache lines and backing SRAM words
  bit          mv [NL];
  logic [31:0] mt [NL];
  logic [31:0] md [NL][2];
  logic [31:0] mem [logic [31:0]];
  int          hc = 0;
  int          mc = 0;

  bit          exp_on = 1'b0;
  logic        exp_ready = 1'b1;
  logic        exp_rchk = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_ren = 1'b0;
  logic        exp_wen = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp_wdata = 32'h0;

  bit          lit_on = 1'b0;
  logic [31:0] lit_rdata = 32'h0;
  logic [31:0] lit_addr = 32'h0;
  int          lit_hit = 0;
  int          lit_miss = 0;
  int          lit_low = 0;
  bit          lit_rseen = 1'b0;
  bit          lit_wseen = 1'b0;

  logic [31:0] cap_rdata = 32'h0;
  logic [31:0] cap_addr = 32'h0;
  bit          cap_r = 1'b0;
  bit          cap_w = 1'b0;
  int          cap_low = 0;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (mem.exists(k)) return mem[k];
    return {k[15:0], ~k[15:0]};
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      chk("ready", 32'(Ready), 32'(exp_ready));
      if (exp_rchk) chk("rdata", rdata, exp_rdata);
      chk("sram_R_EN", 32'(sram_R_EN), 32'(exp_ren));
      chk("sram_W_EN", 32'(sram_W_EN), 32'(exp_wen));
      if (exp_ren || exp_wen)
        chk("sram_addr", sram_addr, exp_addr);
      if (exp_wen)
        chk("sram_wdata", sram_wdata, exp_wdata);
      chk("hit_cnt", 32'(hit_cnt), hc);
      chk("miss_cnt", 32'(miss_cnt), mc);
    end
    if (Mem_R_EN || Mem_W_EN) begin
      if (!Ready) cap_low++;
      if (Ready && Mem_R_EN && !Mem_W_EN) cap_rdata = rdata;
      if (sram_R_EN) begin
        cap_r = 1'b1;
        cap_addr = sram_addr;
      end
      if (sram_W_EN) cap_w = 1'b1;
    end else begin
      if (lit_on) begin
        chk("lit_rdata", cap_rdata, lit_rdata);
        chk("lit_hit_cnt", 32'(hit_cnt), lit_hit);
        if (lit_miss >= 0)
          chk("lit_miss_cnt", 32'(miss_cnt), lit_miss);
        chk("lit_rd_seen", 32'(cap_r), 32'(lit_rseen));
        chk("lit_wr_seen", 32'(cap_w), 32'(lit_wseen));
        chk("lit_low_cycles", cap_low, lit_low);
        chk("lit_fill_addr", cap_addr, lit_addr);
      end
      cap_rdata = 32'h0;
      cap_addr = 32'h0;
      cap_r = 1'b0;
      cap_w = 1'b0;
      cap_low = 0;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    Mem_R_EN = 1'b0;
    Mem_W_EN = 1'b0;
    sram_ready = 1'b0;
    exp_ready = 1'b1;
    exp_rchk = 1'b1;
    exp_rdata = 32'h0;
    exp_ren = 1'b0;
    exp_wen = 1'b0;
  endtask

  task automatic lit(input logic [31:0] rd, input int h,
                     input int m, input bit rs, input bit ws,
                     input int low, input logic [31:0] ad);
    lit_rdata = rd;
    lit_hit = h;
    lit_miss = m;
    lit_rseen = rs;
    lit_wseen = ws;
    lit_low = low;
    lit_addr = ad;
    lit_on = 1'b1;
  endtask

  task automatic txn(input bit r, input bit w,
                     input logic [31:0] a,
                     input logic [31:0] d, input int lat);
    int          idx;
    logic [31:0] tg;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          rd;
    bit          hit;
    idx = int'(a[8:3]);
    tg  = a >> 9;
    rd  = r && !w;
    hit = rd && mv[idx] && (mt[idx] == tg);
    Mem_R_EN = r;
    Mem_W_EN = w;
    addr = a;
    wdata = d;
    sram_ready = 1'b0;
    exp_ren = 1'b0;
    exp_wen = 1'b0;
    exp_ready = hit;
    exp_rchk = hit;
    exp_rdata = md[idx][a[2]];
    step;
    if (hit) begin
      hc = sat(hc + 1);
    end else begin
      if (rd) mc = sat(mc + 1);
      w0 = mem_rd({a[31:3], 3'b000});
      w1 = mem_rd({a[31:3], 3'b100});
      for (int k = 1; k <= lat; k++) begin
        sram_ready = (k == lat);
        sram_rdata = (k == lat) ? {w1, w0} : {~w1, ~w0};
        exp_ren = rd;
        exp_wen = w;
        exp_addr = w ? a : {a[31:3], 3'b000};
        exp_wdata = d;
        exp_ready = (k == lat);
        exp_rchk = rd && (k == lat);
        exp_rdata = a[2] ? w1 : w0;
        step;
      end
      if (rd) begin
        mv[idx] = 1'b1;
        mt[idx] = tg;
        md[idx][0] = w0;
        md[idx][1] = w1;
      end else begin
        mem[{a[31:2], 2'b00}] = d;
        if (mv[idx] && mt[idx] == tg) md[idx][a[2]] = d;
      end
    end
    set_idle;
    step;
    lit_on = 1'b0;
  endtask

  logic [31:0] tbl [6];

  initial begin
    mem[32'h400] = 32'h1111_1111;
    mem[32'h404] = 32'h2222_2222;
    tbl[0] = 32'h0000_01F8;
    tbl[1] = 32'h0000_01FC;
    tbl[2] = 32'h0000_03F8;
    tbl[3] = 32'hFFFF_FFFC;
    tbl[4] = 32'h0000_0010;
    tbl[5] = 32'h1234_5018;
    set_idle;
    exp_on = 1'b1;
    repeat (2) step;
    rst = 1'b1;
    step;

    lit(32'h2222_2222, 0, 1, 1, 0, 5, 32'h400);
    txn(1, 0, 32'h404, 32'h0, 5);
    lit(32'h1111_1111, 1, 1, 0, 0, 0, 32'h0);
    txn(1, 0, 32'h400, 32'h0, 3);
    lit(32'h0, 1, 1, 0, 1, 4, 32'h0);
    txn(0, 1, 32'h404, 32'hDEAD_BEEF, 4);
    lit(32'hDEAD_BEEF, 2, 1, 0, 0, 0, 32'h0);
    txn(1, 0, 32'h404, 32'h0, 1);

    lit(32'h0600_F9FF, 2, 2, 1, 0, 2, 32'h600);
    txn(1, 0, 32'h600, 32'h0, 2);
    lit(32'h1111_1111, 2, 3, 1, 0, 3, 32'h400);
    txn(1, 0, 32'h400, 32'h0, 3);

    lit(32'h0, 2, 3, 0, 1, 2, 32'h0);
    txn(0, 1, 32'h800, 32'hCAFE_F00D, 2);
    lit(32'hCAFE_F00D, 2, 4, 1, 0, 2, 32'h800);
    txn(1, 0, 32'h800, 32'h0, 2);
    lit(32'h0804_F7FB, 3, 4, 0, 0, 0, 32'h0);
    txn(1, 0, 32'h804, 32'h0, 1);

    lit(32'h0, 3, 4, 0, 1, 3, 32'h0);
    txn(1, 1, 32'h404, 32'h1234_5678, 3);
    lit(32'h1234_5678, 3, 5, 1, 0, 1, 32'h400);
    txn(1, 0, 32'h404, 32'h0, 1);
    txn(1, 0, 32'h400, 32'h0, 1);
    txn(0, 1, 32'h400, 32'hA5A5_A5A5, 2);
    txn(1, 0, 32'h400, 32'h0, 1);

    for (int i = 0; i < 6; i++) begin
      txn(1, 0, tbl[i], 32'h0, 1 + (i % 3));
      txn(1, 0, tbl[i] ^ 32'h4, 32'h0, 1);
    end
    for (int i = 0; i < 14; i++) begin
      txn(1, 0, 32'h400, 32'h0, 1);
    end
    lit(32'hA5A5_A5A5, 15, -1, 0, 0, 0, 32'h0);
    txn(1, 0, 32'h400, 32'h0, 1);

    Mem_R_EN = 1'b1;
    addr = 32'hC08;
    exp_ready = 1'b0;
    exp_rchk = 1'b0;
    step;
    mc = sat(mc + 1);
    exp_ren = 1'b1;
    exp_addr = 32'hC08;
    step;
    rst = 1'b0;
    for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    hc = 0;
    mc = 0;
    set_idle;
    repeat (2) step;
    rst = 1'b1;
    step;
    lit(32'h0C08_F3F7, 0, 1, 1, 0, 3, 32'hC08);
    txn(1, 0, 32'hC08, 32'h0, 3);
    lit(32'hA5A5_A5A5, 0, 2, 1, 0, 2, 32'h400);
    txn(1, 0, 32'h400, 32'h0, 2);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_cache.md
Name: mem_cache

Overview:
- Direct-mapped read cache between the MEM stage and the SRAM controller.
- Accepts the MEM stage's 32-bit word requests.
- Serves read hits with zero added latency.
- Fills 64-bit lines from the SRAM controller on a read miss.
- Forwards every write to SRAM (write-through, no write-allocate).
- Its Ready output replaces the SRAM controller's Ready as the MEM-stage freeze/WB-enable qualifier.

Parameters:
- INDEX_W, 6, index bits; number of lines = 2**INDEX_W.
- CNT_W, 16, width of the saturating hit and miss counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Mem_R_EN  in  1  MEM-stage read request.
- Mem_W_EN  in  1  MEM-stage write request.
- addr  in  32  byte address, word aligned; bits [1:0] ignored.
- wdata  in  32  store value.
- rdata  out  32  load result; valid when Ready=1 and Mem_R_EN=1.
- Ready  out  1  request complete this cycle; 1 when idle with no request.
- sram_R_EN  out  1  line-read request to the SRAM controller.
- sram_W_EN  out  1  word-write request to the SRAM controller.
- sram_addr  out  32  byte address to the SRAM controller (line-aligned for reads).
- sram_wdata  out  32  write data to the SRAM controller.
- sram_rdata  in  64  returned line; word0 in [31:0], word1 in [63:32].
- sram_ready  in  1  SRAM controller completion pulse.
- hit_cnt  out  CNT_W  saturating read-hit counter.
- miss_cnt  out  CNT_W  saturating read-miss counter.

Behaviour:
- Address split:
  - word select = addr[2].
  - index = addr[INDEX_W+2:3].
  - tag = addr[31:INDEX_W+3].
- Storage: per line one valid bit, one tag and 64 data bits. Arrays use combinational read and synchronous write.
- Reset (rst=0, asynchronous): all valid bits cleared, state=IDLE, sram_R_EN=0, sram_W_EN=0, hit_cnt=0, miss_cnt=0. Data and tag contents are don't-care.
- Reset asserted during FILL or WRITE aborts the transaction. No line becomes valid.
- State machine: IDLE, FILL, WRITE.
- IDLE:
  - No request: Ready=1, rdata=0.
  - Mem_W_EN=1, whether or not Mem_R_EN is also 1 (write wins): Ready=0, go to WRITE.
  - Mem_R_EN=1 with hit (valid and tag match):
    - Ready=1 in the same cycle.
    - rdata = selected word of the line.
    - hit_cnt increments.
    - Stay in IDLE.
  - Mem_R_EN=1 with miss: Ready=0, go to FILL. miss_cnt increments once, on this transition.
- FILL:
  - sram_R_EN=1 and sram_addr={addr[31:3],3'b000}, held until sram_ready.
  - On sram_ready:
    - Write the line with sram_rdata, set valid and write the tag.
    - Ready=1 in the same cycle, with rdata taken directly from sram_rdata via addr[2] (bypass).
    - Next state IDLE; sram_R_EN deasserts in that next cycle.
- WRITE:
  - sram_W_EN=1, sram_addr=addr, sram_wdata=wdata, held until sram_ready.
  - On sram_ready: Ready=1. If the line hits, the selected word is updated with wdata in the same edge; a missed line is not allocated. Next state IDLE.
- Upstream contract: the MEM stage holds Mem_R_EN, Mem_W_EN, addr and wdata stable while Ready=0. Behaviour on changes mid-transaction is undefined.
- Because Ready is 1 only on the completion cycle, a write is never issued to SRAM twice.
- Counters saturate at all-ones with no wrap. Write transactions do not affect either counter.
- Enables never both 1: sram_R_EN and sram_W_EN are mutually exclusive and both 0 in IDLE.
- Latency:
  - read hit: 0 extra cycles.
  - read miss: 1 cycle plus SRAM latency.
  - write: 1 cycle plus SRAM latency.

Test Plan:
- Reset, then read addr=0x0000_0404 with SRAM returning 0x2222_2222_1111_1111 after 5 cycles:
  - Ready low until the sram_ready cycle.
  - rdata=0x2222_2222.
  - miss_cnt=1.
  - sram_addr=0x0000_0400.
- Then read 0x0000_0400: Ready=1 the same cycle, rdata=0x1111_1111, hit_cnt=1, sram_R_EN stays 0.
- Write 0x0000_0404 with wdata=0xDEAD_BEEF:
  - sram_W_EN high until sram_ready.
  - Subsequent read of 0x0000_0404 hits with rdata=0xDEAD_BEEF.
- Conflict and non-allocation (INDEX_W=6):
  - Read 0x0000_0600 (same index as 0x400, different tag): a miss that evicts the 0x400 line; a following read of 0x0000_0400 misses again, so miss_cnt increments.
  - Write to uncached 0x0000_0800, then read it: the read misses, proving no write-allocate.
- Assert rst=0 mid-FILL, release, then re-read the same address: the read misses and no stale valid line exists.
- Assert Mem_R_EN and Mem_W_EN together: only sram_W_EN asserts, and the counters are unchanged.
